// File: rtl/auto_player_pkg.sv
// Shared definitions for the auto player: FSM states, note and tempo codes,
// ROM word layout and the ROM images (production melodies and a short bring-up image).
package auto_player_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_PLAY   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_MAX  = 4'h7;
    localparam logic [3:0] END_MARK  = 4'hF;

    localparam logic [1:0] TEMPO_NORMAL = 2'b00;
    localparam logic [1:0] TEMPO_FAST   = 2'b01;
    localparam logic [1:0] TEMPO_SLOW   = 2'b10;

    localparam int NOTE_W   = 4;
    localparam int DUR_W    = 4;
    localparam int OCT_W    = 2;
    localparam int OCT_LSB  = 0;
    localparam int DUR_LSB  = OCT_LSB + OCT_W;
    localparam int NOTE_LSB = DUR_LSB + DUR_W;
    localparam int WORD_W   = NOTE_LSB + NOTE_W;

    localparam int ROM_IMAGE_SONGS = 0;
    localparam int ROM_IMAGE_TEST  = 1;

    // Melodies stored one note per nibble, first note in the most significant nibble.
    localparam int               TWINKLE_LEN = 14;
    localparam logic [55:0]      TWINKLE     = 56'h11556654433221;
    localparam int               MARY_LEN    = 7;
    localparam logic [27:0]      MARY        = 28'h3212333;

    function automatic logic [WORD_W-1:0] rom_word(input logic [NOTE_W-1:0] note,
                                                   input logic [DUR_W-1:0]  dur,
                                                   input logic [OCT_W-1:0]  oct);
        return {note, dur, oct};
    endfunction

    function automatic logic [WORD_W-1:0] song_word(input int image, input int song, input int pos);
        logic [WORD_W-1:0] w;
        w = rom_word(END_MARK, 4'd0, 2'd0);
        if (image == ROM_IMAGE_TEST) begin
            case (song)
                0: if (pos == 0) w = rom_word(4'd3, 4'd2, 2'd1);
                1: begin
                    if (pos == 7)     w = rom_word(4'd2, 4'd1, 2'd3);
                    else if (pos < 7) w = rom_word(4'(pos + 1), 4'd1, 2'd0);
                end
                2: begin
                    if (pos == 0)      w = rom_word(4'd5, 4'd3, 2'd2);
                    else if (pos == 1) w = rom_word(4'd6, 4'd3, 2'd0);
                end
                default: ;
            endcase
        end else begin
            case (song)
                0: if (pos < TWINKLE_LEN)
                    w = rom_word(TWINKLE[4*(TWINKLE_LEN-1-pos) +: 4],
                                 (pos == 6 || pos == 13) ? 4'd2 : 4'd1, 2'd1);
                1: begin
                    if (pos < 7)       w = rom_word(4'(pos + 1), 4'd1, 2'd1);
                    else if (pos == 7) w = rom_word(4'd1, 4'd4, 2'd2);
                end
                2: if (pos < MARY_LEN)
                    w = rom_word(MARY[4*(MARY_LEN-1-pos) +: 4],
                                 (pos == MARY_LEN-1) ? 4'd2 : 4'd1, 2'd1);
                default: ;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous song ROM addressed by {song, position}; data is valid one cycle after the address.
module song_rom
    import auto_player_pkg::*;
#(
    parameter int NUM_SONGS = 3,
    parameter int MAX_LEN   = 56,
    parameter int ROM_IMAGE = ROM_IMAGE_SONGS,
    localparam int SONG_W   = $clog2(NUM_SONGS),
    localparam int POS_W    = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic [SONG_W-1:0] i_song,
    input  logic [POS_W-1:0]  i_pos,
    output logic [WORD_W-1:0] o_data
);

    logic [WORD_W-1:0] r_data;

    // NOTE: ROM output register has no reset; the FSM never consumes it before a FETCH cycle.
    always_ff @(posedge clk) begin
        if (int'(i_song) < NUM_SONGS && int'(i_pos) < MAX_LEN)
            r_data <= song_word(ROM_IMAGE, int'(i_song), int'(i_pos));
        else
            r_data <= rom_word(END_MARK, 4'd0, 2'd0);
    end

    assign o_data = r_data;

endmodule

// File: rtl/auto_player.sv
// Automatic song player: fetches notes from song_rom, times each note with a tempo-scaled
// counter, inserts a silent gap, and handles pause, song select and loop/advance.
module auto_player
    import auto_player_pkg::*;
#(
    parameter int NUM_SONGS   = 3,
    parameter int MAX_LEN     = 56,
    parameter int TICK_CYCLES = 10000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int ROM_IMAGE   = ROM_IMAGE_SONGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] song_select,
    input  logic       pause,
    input  logic [1:0] tempo_sel,
    input  logic       loop_mode,
    output logic [3:0] note_to_play,
    output logic [1:0] octave_auto,
    output logic [6:0] led_out,
    output logic [3:0] num,
    output logic       playing
);

    localparam int SONG_W = $clog2(NUM_SONGS);
    localparam int POS_W  = $clog2(MAX_LEN);
    localparam int CNT_W  = $clog2(30 * TICK_CYCLES + 1);

    localparam logic [CNT_W-1:0]  UNIT_NORMAL = CNT_W'(TICK_CYCLES);
    localparam logic [CNT_W-1:0]  UNIT_FAST   = CNT_W'(TICK_CYCLES / 2);
    localparam logic [CNT_W-1:0]  UNIT_SLOW   = CNT_W'(2 * TICK_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_LEN     = CNT_W'(GAP_CYCLES);
    localparam logic [SONG_W-1:0] LAST_SONG   = SONG_W'(NUM_SONGS - 1);
    localparam logic [POS_W-1:0]  LAST_POS    = POS_W'(MAX_LEN - 1);

    state_t            r_state, w_state_nx;
    logic [SONG_W-1:0] r_song,  w_song_nx;
    logic [POS_W-1:0]  r_pos,   w_pos_nx;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nx;
    logic [3:0]        r_note,  w_note_nx;
    logic [1:0]        r_oct,   w_oct_nx;
    logic [6:0]        r_led,   w_led_nx;
    logic [1:0]        r_sel_prev;

    logic [1:0]        w_sel_rise;
    logic              w_sel_next;
    logic              w_sel_prev;
    logic [WORD_W-1:0] w_rom_data;
    logic [NOTE_W-1:0] w_rom_note;
    logic [DUR_W-1:0]  w_rom_dur;
    logic [OCT_W-1:0]  w_rom_oct;
    logic [CNT_W-1:0]  w_unit;
    logic [CNT_W-1:0]  w_note_len;

    song_rom #(
        .NUM_SONGS (NUM_SONGS),
        .MAX_LEN   (MAX_LEN),
        .ROM_IMAGE (ROM_IMAGE)
    ) u_song_rom (
        .clk    (clk),
        .i_song (r_song),
        .i_pos  (r_pos),
        .o_data (w_rom_data)
    );

    assign w_rom_note = w_rom_data[NOTE_LSB +: NOTE_W];
    assign w_rom_dur  = w_rom_data[DUR_LSB  +: DUR_W];
    assign w_rom_oct  = w_rom_data[OCT_LSB  +: OCT_W];

    // Simultaneous next and previous edges cancel each other out.
    assign w_sel_rise = song_select & ~r_sel_prev;
    assign w_sel_next = w_sel_rise[0] & ~w_sel_rise[1];
    assign w_sel_prev = w_sel_rise[1] & ~w_sel_rise[0];

    function automatic logic [6:0] led_decode(input logic [3:0] note);
        logic [6:0] led;
        led = '0;
        if (note != NOTE_REST && note <= NOTE_MAX)
            led = 7'b1 << (note - 4'd1);
        return led;
    endfunction

    always_comb begin
        case (tempo_sel)
            TEMPO_FAST:   w_unit = UNIT_FAST;
            TEMPO_SLOW:   w_unit = UNIT_SLOW;
            TEMPO_NORMAL: w_unit = UNIT_NORMAL;
            default:      w_unit = UNIT_NORMAL;
        endcase
        w_note_len = (CNT_W'((w_rom_dur == '0) ? 4'd1 : w_rom_dur) * w_unit) - GAP_LEN;
    end

    // NOTE: every next-state signal gets a hold default first so no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        w_song_nx  = r_song;
        w_pos_nx   = r_pos;
        w_cnt_nx   = r_cnt;
        w_note_nx  = r_note;
        w_oct_nx   = r_oct;
        w_led_nx   = r_led;

        if (w_sel_next || w_sel_prev) begin
            if (w_sel_next)
                w_song_nx = (r_song == LAST_SONG) ? '0 : r_song + 1'b1;
            else
                w_song_nx = (r_song == '0) ? LAST_SONG : r_song - 1'b1;
            w_pos_nx   = '0;
            w_cnt_nx   = '0;
            w_note_nx  = NOTE_REST;
            w_led_nx   = '0;
            w_state_nx = ST_FETCH;
        end else if (!pause) begin
            case (r_state)
                ST_FETCH: w_state_nx = ST_DECODE;
                ST_DECODE: begin
                    if (w_rom_note > NOTE_MAX) begin
                        w_pos_nx = '0;
                        if (!loop_mode)
                            w_song_nx = (r_song == LAST_SONG) ? '0 : r_song + 1'b1;
                        w_state_nx = ST_FETCH;
                    end else begin
                        w_note_nx  = w_rom_note;
                        w_oct_nx   = w_rom_oct;
                        w_led_nx   = led_decode(w_rom_note);
                        w_cnt_nx   = w_note_len;
                        w_state_nx = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nx   = '0;
                        w_note_nx  = NOTE_REST;
                        w_led_nx   = '0;
                        w_state_nx = ST_GAP;
                    end else begin
                        w_cnt_nx = r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LEN - 1'b1) begin
                        w_cnt_nx   = '0;
                        w_pos_nx   = (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
                        w_state_nx = ST_FETCH;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                default: w_state_nx = ST_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_FETCH;
            r_song     <= '0;
            r_pos      <= '0;
            r_cnt      <= '0;
            r_note     <= NOTE_REST;
            r_oct      <= '0;
            r_led      <= '0;
            r_sel_prev <= 2'b00;
        end else begin
            r_state    <= w_state_nx;
            r_song     <= w_song_nx;
            r_pos      <= w_pos_nx;
            r_cnt      <= w_cnt_nx;
            r_note     <= w_note_nx;
            r_oct      <= w_oct_nx;
            r_led      <= w_led_nx;
            r_sel_prev <= song_select;
        end
    end

    // Pause silences the outputs without disturbing the held note, so release restores it.
    assign note_to_play = pause ? NOTE_REST : r_note;
    assign led_out      = pause ? 7'd0 : r_led;
    assign octave_auto  = r_oct;
    assign num          = 4'(r_song);
    assign playing      = (r_state == ST_PLAY) && !pause;

endmodule

// File: tb/tb_auto_player.sv
// Self-checking bench for auto_player using the bring-up ROM image (TICK=4, GAP=1, MAX_LEN=8).
module tb_auto_player;
    import auto_player_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] song_select = 2'b00;
    logic       pause = 1'b0;
    logic [1:0] tempo_sel = 2'b00;
    logic       loop_mode = 1'b1;
    logic [3:0] note_to_play;
    logic [1:0] octave_auto;
    logic [6:0] led_out;
    logic [3:0] num;
    logic       playing;

    auto_player #(
        .NUM_SONGS   (3),
        .MAX_LEN     (8),
        .TICK_CYCLES (4),
        .GAP_CYCLES  (1),
        .ROM_IMAGE   (ROM_IMAGE_TEST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .song_select  (song_select),
        .pause        (pause),
        .tempo_sel    (tempo_sel),
        .loop_mode    (loop_mode),
        .note_to_play (note_to_play),
        .octave_auto  (octave_auto),
        .led_out      (led_out),
        .num          (num),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] note;
        logic [1:0] oct;
        logic       chk_oct;
        logic [6:0] led;
        logic [3:0] num;
        logic       play;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic       pause;
        logic [1:0] tempo;
        logic       loop;
        int         cyc;
        exp_t       exp;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t mk_exp(input string name, input logic [3:0] note, input logic [1:0] oct,
                                    input logic chk_oct, input logic [6:0] led, input logic [3:0] n,
                                    input logic play);
        exp_t e;
        e.name = name; e.note = note; e.oct = oct; e.chk_oct = chk_oct;
        e.led = led; e.num = n; e.play = play;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [1:0] sel, input logic p, input logic [1:0] tempo,
                                    input logic loop, input int cyc, input exp_t e);
        vec_t v;
        v.sel = sel; v.pause = p; v.tempo = tempo; v.loop = loop; v.cyc = cyc; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".note"}, 32'(note_to_play), 32'(e.note));
        if (e.chk_oct) check({e.name, ".oct"}, 32'(octave_auto), 32'(e.oct));
        check({e.name, ".led"}, 32'(led_out), 32'(e.led));
        check({e.name, ".num"}, 32'(num), 32'(e.num));
        check({e.name, ".playing"}, 32'(playing), 32'(e.play));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input int n, input exp_t e);
        sb.push_back(e);
        tick(n);
        compare_out();
    endtask

    task automatic now(input exp_t e);
        sb.push_back(e);
        #1;
        compare_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];

        // Cycle k = number of rising edges since reset release; k noted per row.
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 1,  1, mk_exp("k01_decode",    0, 0, 1, 7'h00, 0, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 1,  1, mk_exp("k02_first",     3, 1, 1, 7'h04, 0, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 1,  6, mk_exp("k08_last_play", 3, 1, 1, 7'h04, 0, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 1,  1, mk_exp("k09_gap",       0, 1, 1, 7'h00, 0, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 1,  4, mk_exp("k13_decode",    0, 1, 1, 7'h00, 0, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 1,  1, mk_exp("k14_loop",      3, 1, 1, 7'h04, 0, 1)));
        vecs.push_back(mk_vec(2'b10, 0, 2'b00, 1,  1, mk_exp("k15_prev_0to2", 0, 0, 0, 7'h00, 2, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 1,  2, mk_exp("k17_song2",     5, 2, 1, 7'h10, 2, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0, 10, mk_exp("k27_tempo_mid", 5, 2, 1, 7'h10, 2, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  1, mk_exp("k28_gap",       0, 2, 1, 7'h00, 2, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  3, mk_exp("k31_fast",      6, 0, 1, 7'h20, 2, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  4, mk_exp("k35_fast_end",  6, 0, 1, 7'h20, 2, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  1, mk_exp("k36_fast_gap",  0, 0, 1, 7'h00, 2, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  2, mk_exp("k38_end_dec",   0, 0, 1, 7'h00, 2, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  1, mk_exp("k39_advance",   0, 0, 1, 7'h00, 0, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  2, mk_exp("k41_song0",     3, 1, 1, 7'h04, 0, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  2, mk_exp("k43_song0_end", 3, 1, 1, 7'h04, 0, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  1, mk_exp("k44_gap",       0, 1, 1, 7'h00, 0, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  3, mk_exp("k47_song1",     0, 1, 1, 7'h00, 1, 0)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b01, 0,  2, mk_exp("k49_s1p0",      1, 0, 1, 7'h01, 1, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 0,  4, mk_exp("k53_s1p1",      2, 0, 1, 7'h02, 1, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 0, 36, mk_exp("k89_s1p7",      2, 3, 1, 7'h02, 1, 1)));
        vecs.push_back(mk_vec(2'b00, 0, 2'b00, 0,  6, mk_exp("k95_wrap_p0",   1, 0, 1, 7'h01, 1, 1)));

        repeat (3) @(negedge clk);
        now(mk_exp("reset_state", 0, 0, 1, 7'h00, 0, 0));
        reset = 1'b1;

        foreach (vecs[i]) begin
            song_select = vecs[i].sel;
            pause       = vecs[i].pause;
            tempo_sel   = vecs[i].tempo;
            loop_mode   = vecs[i].loop;
            step(vecs[i].cyc, vecs[i].exp);
        end

        // Song select: next on song 1 and song 2, then both edges together.
        song_select = 2'b01;
        step(1, mk_exp("k96_next_1to2", 0, 0, 0, 7'h00, 2, 0));
        song_select = 2'b00;
        tick(1);
        song_select = 2'b01;
        step(1, mk_exp("k98_next_2to0", 0, 0, 0, 7'h00, 0, 0));
        song_select = 2'b00;
        step(2, mk_exp("k100_song0", 3, 1, 1, 7'h04, 0, 1));
        tick(1);
        song_select = 2'b11;
        step(1, mk_exp("k102_both_edges", 3, 1, 1, 7'h04, 0, 1));
        song_select = 2'b00;
        tick(1);

        // Pause for 10 cycles mid-note: the note must end exactly 10 cycles later.
        pause = 1'b1;
        now(mk_exp("pause_on", 0, 1, 1, 7'h00, 0, 0));
        step(10, mk_exp("k113_paused", 0, 1, 1, 7'h00, 0, 0));
        pause     = 1'b0;
        loop_mode = 1'b1;
        now(mk_exp("pause_release", 3, 1, 1, 7'h04, 0, 1));
        step(3, mk_exp("k116_resumed_end", 3, 1, 1, 7'h04, 0, 1));
        step(1, mk_exp("k117_gap", 0, 1, 1, 7'h00, 0, 0));
        step(5, mk_exp("k122_loop", 3, 1, 1, 7'h04, 0, 1));

        // Slow tempo on a duration-3 note: 23 sounding cycles plus one gap cycle.
        tempo_sel   = 2'b10;
        song_select = 2'b10;
        step(1, mk_exp("k123_prev_0to2", 0, 0, 0, 7'h00, 2, 0));
        song_select = 2'b00;
        step(2, mk_exp("k125_slow", 5, 2, 1, 7'h10, 2, 1));
        step(22, mk_exp("k147_slow_end", 5, 2, 1, 7'h10, 2, 1));
        step(1, mk_exp("k148_slow_gap", 0, 2, 1, 7'h00, 2, 0));
        step(3, mk_exp("k151_note6", 6, 0, 1, 7'h20, 2, 1));
        tick(2);

        // Asynchronous reset mid-note, with song_select held high through release.
        reset       = 1'b0;
        song_select = 2'b01;
        now(mk_exp("async_reset", 0, 0, 1, 7'h00, 0, 0));
        tick(2);
        reset = 1'b1;
        step(1, mk_exp("rel_held_edge", 0, 0, 1, 7'h00, 1, 0));
        step(2, mk_exp("rel_s1_first", 1, 0, 1, 7'h01, 1, 1));
        song_select = 2'b00;
        step(1, mk_exp("rel_sel_drop", 1, 0, 1, 7'h01, 1, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/auto_player.md
# auto_player

Parametrised automatic song player, successor to the single-song auto mode. Plays stored melodies from an internal song ROM, with per-note duration, octave and LED mapping, over a configurable number of songs and song length. Adds pause, tempo selection, an articulation gap between notes, and a choice of looping or auto-advancing songs. Sits between the mode mux and the buzzer tone generator.

## Interface
- NUM_SONGS, 3: songs in ROM (≥2)
- MAX_LEN, 56: max notes per song; position wraps here
- TICK_CYCLES, 10000000: clk cycles per duration unit at normal tempo (even, ≥4)
- GAP_CYCLES, 500000: silent cycles at end of each note (< TICK_CYCLES/2)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- song_select  in  2  bit0 = next song, bit1 = previous song; level inputs, rising-edge detected internally
- pause  in  1  1 = freeze playback and silence outputs
- tempo_sel  in  2  00 normal, 01 fast (unit = TICK_CYCLES/2), 10 slow (unit = 2·TICK_CYCLES), 11 normal
- loop_mode  in  1  1 = repeat current song at end; 0 = advance to next song
- note_to_play  out  4  0 rest, 1–7 notes
- octave_auto  out  2  octave of current note
- led_out  out  7  one-hot of note (bit n-1 for note n); 0 for rest
- num  out  4  current song index, zero-extended
- playing  out  1  1 in PLAY state and not paused

## Operation
- ROM word per (song, position): note[3:0], duration[3:0] (units; 0 treated as 1), octave[1:0]. Note 4'hF = end marker.
- FSM: FETCH (address ROM) → DECODE (ROM data valid) → PLAY → GAP → FETCH.
- DECODE, normal note: register note/octave/led outputs, load counter = duration·unit − GAP_CYCLES, go PLAY.
- DECODE, end marker or note 8–14: position ← 0; if loop_mode=0, song index advances (wrap NUM_SONGS-1→0); go FETCH. Outputs unchanged.
- PLAY: decrement to 0 → GAP, outputs forced to rest (note 0, led 0, octave held). GAP: count GAP_CYCLES → position+1 (MAX_LEN-1 wraps to 0) → FETCH.
- Unit length sampled in DECODE; tempo change affects next note only.
- pause=1: counters and state frozen, note_to_play=0, led_out=0, playing=0; on release, outputs restored from held note if in PLAY.
- Song-select edge (any state, including paused): next wraps NUM_SONGS-1→0, prev wraps 0→NUM_SONGS-1; both edges same cycle → no change, no restart. On change: position 0, counter 0, outputs rest, state FETCH.
- Edge detector previous-value register resets to 2'b00; a level held high through reset release counts as one edge.

## Timing
- Reset values: note_to_play 0, octave_auto 0, led_out 0, num 0, playing 0, state FETCH, position 0.
- ROM read latency 1 cycle. First note visible 2 cycles after reset deassertion (FETCH, DECODE).
- Note period = duration·unit + 2 cycles (FETCH+DECODE) of which last GAP_CYCLES are rest.
- Song-select edge takes effect on the next edge; new song's first note 3 cycles after the select edge cycle.
- Counter width $clog2(30·TICK_CYCLES+1); no overflow at duration 15 slow.

## Structure
- Package auto_player_pkg: state enum, note codes (REST, END_MARK), tempo codes, ROM word field widths/offsets.
- Sub-module song_rom: synchronous ROM, address {song, position}, one-cycle latency, parametrised by NUM_SONGS/MAX_LEN.
- Top holds FSM, edge detector, duration counter, LED decode.

## Test plan
(TICK_CYCLES=4, GAP_CYCLES=1, MAX_LEN=8, test ROM.)
- Reset release, song 0 = {note 3 dur 2 oct 1, end}: note_to_play=3, led_out=7'b0000100, octave_auto=1 at cycle 2, rest after 7 cycles, 1 gap cycle, then song 0 restarts (loop_mode=1).
- loop_mode=0, song 2 reaches end marker → num=0, position 0, song 0 first note follows 2 cycles later.
- song_select=2'b01 pulse on song 2 → num=0; 2'b10 pulse on song 0 → num=2; 2'b11 rising together → num unchanged, playback not restarted.
- pause mid-note for 10 cycles → outputs 0, playing=0, remaining count unchanged; release → same note resumes, total note length extended by exactly 10.
- tempo_sel=01 then 10 on duration-3 note → play lengths 6 and 24 cycles (incl. gap); change mid-note affects next note only.
- reset asserted mid-PLAY → all outputs 0 immediately (asynchronous), num=0; song with 8 notes and no end marker wraps position 7→0.
